// File: rtl/ariane_pkg.sv
// Shared core types used by the LSU dispatch path: functional-unit tag and
// the bypass-FIFO request record.
`default_nettype none

package ariane_pkg;

  typedef enum logic [3:0] {
    NONE      = 4'd0,
    LOAD      = 4'd1,
    STORE     = 4'd2,
    ALU       = 4'd3,
    CTRL_FLOW = 4'd4,
    MULT      = 4'd5,
    CSR       = 4'd6,
    FPU       = 4'd7,
    FPU_VEC   = 4'd8,
    CVXIF     = 4'd9
  } fu_t;

  typedef struct packed {
    logic        valid;
    logic [63:0] vaddr;
    logic        overflow;
    logic [63:0] data;
    logic [7:0]  be;
    fu_t         fu;
    logic [7:0]  operation;
    logic [2:0]  trans_id;
  } lsu_ctrl_t;

endpackage

`default_nettype wire

// File: rtl/lsu_dispatch_ctrl.sv
// Routes the bypass-FIFO head to the load or store unit, holds it until
// accepted, pops it exactly once, and counts stall cycles of the head.
`default_nettype none

module lsu_dispatch_ctrl
  import ariane_pkg::*;
#(
  parameter int unsigned STALL_W = 8
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               flush_i,
  input  lsu_ctrl_t          lsu_ctrl_i,
  input  logic               ld_ready_i,
  input  logic               st_ready_i,
  input  logic               ld_accept_i,
  input  logic               st_accept_i,
  output logic               ld_valid_o,
  output logic               st_valid_o,
  output logic               pop_ld_o,
  output logic               pop_st_o,
  output logic               busy_o,
  output logic [STALL_W-1:0] stall_cnt_o
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LD_PEND = 2'd1,
    ST_PEND = 2'd2
  } state_e;

  localparam logic [STALL_W-1:0] STALL_MAX = '1;

  state_e             state_q, state_d;
  logic [STALL_W-1:0] stall_q, stall_d;
  logic               ld_valid, st_valid, pop_ld, pop_st;
  logic               head_ld, head_st, head_illegal, waiting;
  logic               unused_ctrl;

  // Only valid and fu steer dispatch; the payload passes straight to the units.
  assign unused_ctrl  = ^lsu_ctrl_i;

  assign head_ld      = lsu_ctrl_i.valid && (lsu_ctrl_i.fu == LOAD);
  assign head_st      = lsu_ctrl_i.valid && (lsu_ctrl_i.fu == STORE);
  assign head_illegal = lsu_ctrl_i.valid && !head_ld && !head_st;

  always_comb begin
    state_d  = state_q;
    ld_valid = 1'b0;
    st_valid = 1'b0;
    pop_ld   = 1'b0;
    pop_st   = 1'b0;
    case (state_q)
      IDLE: begin
        if (head_ld && ld_ready_i) begin
          ld_valid = 1'b1;
          if (ld_accept_i) pop_ld = 1'b1;
          else             state_d = LD_PEND;
        end else if (head_st && st_ready_i) begin
          st_valid = 1'b1;
          if (st_accept_i) pop_st = 1'b1;
          else             state_d = ST_PEND;
        end
      end
      LD_PEND: begin
        // Committed to the unit: ready may drop, valid must not.
        ld_valid = 1'b1;
        if (ld_accept_i) begin
          pop_ld  = 1'b1;
          state_d = IDLE;
        end
      end
      ST_PEND: begin
        st_valid = 1'b1;
        if (st_accept_i) begin
          pop_st  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (flush_i) begin
      ld_valid = 1'b0;
      st_valid = 1'b0;
      pop_ld   = 1'b0;
      pop_st   = 1'b0;
      state_d  = IDLE;
    end
  end

  assign waiting = (state_q != IDLE) || lsu_ctrl_i.valid;

  always_comb begin
    stall_d = stall_q;
    if (flush_i || pop_ld || pop_st || !waiting) stall_d = '0;
    else if (stall_q != STALL_MAX)               stall_d = stall_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      stall_q <= stall_d;
    end
  end

  assign ld_valid_o  = ld_valid & rst_ni;
  assign st_valid_o  = st_valid & rst_ni;
  assign pop_ld_o    = pop_ld & rst_ni;
  assign pop_st_o    = pop_st & rst_ni;
  assign busy_o      = (state_q != IDLE);
  assign stall_cnt_o = stall_q;

`ifndef SYNTHESIS
  a_illegal_fu: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(state_q == IDLE && head_illegal));
  a_pop_onehot: assert property (@(posedge clk_i) !(pop_ld_o && pop_st_o));
  a_valid_onehot: assert property (@(posedge clk_i) !(ld_valid_o && st_valid_o));
`endif

endmodule

`default_nettype wire

// File: tb/tb_lsu_dispatch_ctrl.sv
// Directed and randomized bench for lsu_dispatch_ctrl against a behavioural
// "committed request" model of the dispatch rules.
`default_nettype none

module tb_lsu_dispatch_ctrl;
  import ariane_pkg::*;

  localparam int STALL_W = 8;
  localparam int SAT     = (1 << STALL_W) - 1;

  logic              clk_i = 1'b0;
  logic              rst_ni;
  logic              flush_i;
  lsu_ctrl_t         head;
  logic              ld_ready_i, st_ready_i, ld_accept_i, st_accept_i;
  logic              ld_valid_o, st_valid_o, pop_ld_o, pop_st_o, busy_o;
  logic [STALL_W-1:0] stall_cnt_o;

  int checks = 0;
  int errors = 0;

  // Reference model: is a request committed to a unit, which one, and how long
  // the current head has been waiting.
  bit m_committed;
  bit m_unit_st;
  int m_cnt;
  bit last_pop;

  always #5 clk_i = ~clk_i;

  lsu_dispatch_ctrl #(.STALL_W(STALL_W)) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .flush_i     (flush_i),
    .lsu_ctrl_i  (head),
    .ld_ready_i  (ld_ready_i),
    .st_ready_i  (st_ready_i),
    .ld_accept_i (ld_accept_i),
    .st_accept_i (st_accept_i),
    .ld_valid_o  (ld_valid_o),
    .st_valid_o  (st_valid_o),
    .pop_ld_o    (pop_ld_o),
    .pop_st_o    (pop_st_o),
    .busy_o      (busy_o),
    .stall_cnt_o (stall_cnt_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit exp_valid(input bit is_st);
    bit want;
    if (m_committed) want = (m_unit_st == is_st);
    else if (is_st)  want = head.valid && head.fu == STORE && st_ready_i;
    else             want = head.valid && head.fu == LOAD && ld_ready_i;
    return want && !flush_i && rst_ni;
  endfunction

  // Check one cycle against the model, then advance the model across the edge.
  task automatic step(input string tag);
    bit e_ldv, e_stv, e_popl, e_pops, popped;
    e_ldv  = exp_valid(1'b0);
    e_stv  = exp_valid(1'b1);
    e_popl = e_ldv && ld_accept_i;
    e_pops = e_stv && st_accept_i;
    #2;
    chk({tag, ".ld_valid"}, 32'(ld_valid_o), 32'(e_ldv));
    chk({tag, ".st_valid"}, 32'(st_valid_o), 32'(e_stv));
    chk({tag, ".pop_ld"},   32'(pop_ld_o),   32'(e_popl));
    chk({tag, ".pop_st"},   32'(pop_st_o),   32'(e_pops));
    chk({tag, ".busy"},     32'(busy_o),     32'(m_committed));
    chk({tag, ".stall"},    32'(stall_cnt_o), 32'(m_cnt));
    @(posedge clk_i);
    popped   = e_popl || e_pops;
    last_pop = popped;
    if (!rst_ni || flush_i) begin
      m_committed = 1'b0;
      m_cnt       = 0;
    end else begin
      if (popped || !(m_committed || head.valid)) m_cnt = 0;
      else if (m_cnt < SAT)                       m_cnt = m_cnt + 1;
      m_committed = (e_ldv || e_stv) && !popped;
      if (e_ldv || e_stv) m_unit_st = e_stv;
    end
    #1;
  endtask

  task automatic set_head(input bit v, input fu_t fu);
    head       = '0;
    head.valid = v;
    head.fu    = fu;
    head.vaddr = {$urandom, $urandom};
  endtask

  task automatic idle_inputs();
    flush_i     = 1'b0;
    ld_ready_i  = 1'b0;
    st_ready_i  = 1'b0;
    ld_accept_i = 1'b0;
    st_accept_i = 1'b0;
    set_head(1'b0, LOAD);
  endtask

  initial begin
    rst_ni = 1'b0;
    idle_inputs();
    m_committed = 1'b0;
    m_unit_st   = 1'b0;
    m_cnt       = 0;
    @(posedge clk_i);
    #1;
    step("reset");
    rst_ni = 1'b1;
    step("post_reset");

    // Load accepted in the same cycle it is presented.
    set_head(1'b1, LOAD); ld_ready_i = 1'b1; ld_accept_i = 1'b1;
    step("ld_imm");
    idle_inputs();
    step("ld_imm_after");

    // Store accepted three cycles late; ready drops while pending.
    set_head(1'b1, STORE); st_ready_i = 1'b1;
    step("st_c0");
    st_ready_i = 1'b0;
    step("st_c1");
    step("st_c2");
    st_accept_i = 1'b1;
    step("st_c3");
    idle_inputs();
    chk("st_stall_cleared", 32'(stall_cnt_o), 32'd0);
    step("st_c4");

    // Unready load unit: no dispatch, counter saturates.
    set_head(1'b1, LOAD);
    for (int i = 0; i < 300; i++) step("ld_stall");
    chk("stall_saturated", 32'(stall_cnt_o), 32'(SAT));
    ld_ready_i = 1'b1; ld_accept_i = 1'b1;
    step("ld_stall_release");
    idle_inputs();
    step("ld_stall_after");

    // Flush while pending, accept in the same cycle is ignored.
    set_head(1'b1, LOAD); ld_ready_i = 1'b1;
    step("fl_enter");
    flush_i = 1'b1; ld_accept_i = 1'b1;
    step("fl_flush");
    idle_inputs();
    chk("fl_busy_cleared", 32'(busy_o), 32'd0);
    step("fl_after");

    // Back-to-back load, store, load.
    ld_ready_i = 1'b1; st_ready_i = 1'b1;
    set_head(1'b1, LOAD);  ld_accept_i = 1'b1; st_accept_i = 1'b0;
    step("b2b_ld0");
    set_head(1'b1, STORE); ld_accept_i = 1'b0; st_accept_i = 1'b1;
    step("b2b_st1");
    set_head(1'b1, LOAD);  ld_accept_i = 1'b1; st_accept_i = 1'b0;
    step("b2b_ld2");
    idle_inputs();
    step("b2b_after");

    // Reset while a store is pending.
    set_head(1'b1, STORE); st_ready_i = 1'b1;
    step("rst_enter");
    step("rst_pend");
    rst_ni = 1'b0;
    step("rst_low0");
    step("rst_low1");
    rst_ni = 1'b1;
    idle_inputs();
    chk("rst_busy_cleared", 32'(busy_o), 32'd0);
    step("rst_after");

    // Randomized traffic with a stable head until pop, flush or reset.
    for (int i = 0; i < 3000; i++) begin
      if (!head.valid && $urandom_range(0, 3) != 0)
        set_head(1'b1, ($urandom_range(0, 1) != 0) ? STORE : LOAD);
      ld_ready_i  = ($urandom_range(0, 2) != 0);
      st_ready_i  = ($urandom_range(0, 2) != 0);
      flush_i     = ($urandom_range(0, 31) == 0);
      rst_ni      = ($urandom_range(0, 63) != 0);
      ld_accept_i = exp_valid(1'b0) && ($urandom_range(0, 2) == 0);
      st_accept_i = exp_valid(1'b1) && ($urandom_range(0, 2) == 0);
      step("rand");
      if (last_pop || flush_i || !rst_ni) head.valid = 1'b0;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/lsu_dispatch_ctrl.md
# lsu_dispatch_ctrl

Sequencer between the LSU bypass FIFO and the load/store units. It takes the request at the head of the bypass, routes it to the load unit or the store unit, and holds it stable until that unit accepts it. On acceptance it issues exactly one `pop_ld`/`pop_st` back to the bypass. It also keeps a saturating stall counter for performance monitoring.

## Interface
Parameters:
- `STALL_W`, default 8: width of the stall counter.

Ports:
- `clk_i`, in, 1: clock.
- `rst_ni`, in, 1: reset, synchronous and active-low.
- `flush_i`, in, 1: pipeline flush; aborts any pending dispatch.
- `lsu_ctrl_i`, in, `lsu_ctrl_t`: head of the bypass FIFO. Fields used: `valid` and `fu` (LOAD/STORE).
- `ld_ready_i`, in, 1: load unit can take a new request.
- `st_ready_i`, in, 1: store unit can take a new request.
- `ld_accept_i`, in, 1: load unit accepted the presented request this cycle. Legal only while `ld_valid_o` = 1.
- `st_accept_i`, in, 1: store unit accepted the presented request this cycle. Legal only while `st_valid_o` = 1.
- `ld_valid_o`, out, 1: request presented to the load unit.
- `st_valid_o`, out, 1: request presented to the store unit.
- `pop_ld_o`, out, 1: pop the bypass head after a load was accepted.
- `pop_st_o`, out, 1: pop the bypass head after a store was accepted.
- `busy_o`, out, 1: a dispatch is pending (state ≠ IDLE).
- `stall_cnt_o`, out, `STALL_W`: consecutive cycles the current head has waited.

## Operation
States: IDLE, LD_PEND, ST_PEND.

IDLE:
- `lsu_ctrl_i.valid` with `fu` = LOAD and `ld_ready_i`: assert `ld_valid_o`.
  - If `ld_accept_i` arrives in the same cycle: assert `pop_ld_o` and stay in IDLE.
  - Otherwise go to LD_PEND.
- STORE is symmetric, using `st_ready_i`, `st_valid_o`, `st_accept_i`, `pop_st_o` and ST_PEND.
- Valid head whose unit is not ready: no valid is driven, stay in IDLE, the stall counter counts.
- Valid head with any other `fu` value: illegal. It is not dispatched, and a simulation assertion fires.

LD_PEND:
- `ld_valid_o` stays high regardless of `ld_ready_i` (the request is committed to the unit).
- On `ld_accept_i`: assert `pop_ld_o`, go to IDLE.

ST_PEND: symmetric to LD_PEND.

Invariants:
- `pop_ld_o` and `pop_st_o` are never high in the same cycle.
- `ld_valid_o` and `st_valid_o` are never high in the same cycle.
- At most one pop per accepted request.
- The bypass head is not popped while pending, so it stays stable; the block does not latch request content.

Flush:
- Forces `ld_valid_o`, `st_valid_o`, `pop_ld_o` and `pop_st_o` to 0 in the flush cycle. Accepts in that cycle are ignored.
- Next state is IDLE and the counter clears.

Stall counter:
- Increments each cycle a valid head is not popped.
- Saturates at 2^`STALL_W`−1.
- Clears to 0 in the cycle after a pop, and on flush.

## Timing
- Dispatch has zero latency: valid out follows head valid and ready combinationally.
- Pop is combinational from accept; this path must be kept short, and unit-side accept timing owns it.
- Best-case throughput is one request per cycle: accept in IDLE, pop, and the new head is presented next cycle.
- Reset (`rst_ni` low at a clock edge):
  - state becomes IDLE and `stall_cnt_o` becomes 0;
  - all valid/pop outputs are gated to 0 combinationally while `rst_ni` = 0;
  - `busy_o` = 0 after reset.
- Reset while pending: the pending request is abandoned silently, identical to flush.
- `busy_o` and `stall_cnt_o` are registered.
- Flush and accept in the same cycle: flush wins.

## Structure
- `lsu_ctrl_t` and `fu_t` stay in `ariane_pkg`.
- The state enum is local to the block.
- No sub-module. The counter is inline (about 150 lines of RTL).

## Test plan
- Load head, `ld_ready_i` = 1, `ld_accept_i` = 1 in the same cycle: `ld_valid_o` = 1 and `pop_ld_o` = 1 in cycle 0; state IDLE; `busy_o` = 0 next cycle.
- Store head, `st_ready_i` = 1, `st_accept_i` delayed 3 cycles:
  - `st_valid_o` high for 4 cycles;
  - `busy_o` = 1 for cycles 1–3;
  - `pop_st_o` only in cycle 3;
  - `stall_cnt_o` reads 1, 2, 3, then 0.
- Load head with `ld_ready_i` = 0 for 300 cycles (`STALL_W` = 8): no `ld_valid_o`; `stall_cnt_o` saturates at 255.
- Flush in LD_PEND, with `ld_accept_i` high in the same cycle: `pop_ld_o` = 0 and all outputs 0 that cycle; next cycle state IDLE and counter 0.
- Back-to-back load, store, load, each accepted immediately: pops in cycles 0, 1, 2 are `pop_ld`, `pop_st`, `pop_ld`, never overlapping.
- `rst_ni` = 0 mid ST_PEND: outputs 0 during reset; after release `busy_o` = 0 and `stall_cnt_o` = 0.
